prio_arbiter_rr: RTL and testbench

//  Parametrised N-way request arbiter: registered successor to the 8-to-3 priority encoder.
//  - Selects one of N request lines and holds that grant until it is released.
//  - Issues the grant both as a binary index and as a one-hot vector.
//  - Two modes: fixed priority (highest index wins) or round-robin.
//  - Sits between bus requesters and a shared resource.
//  - Optional hold timeout, so one requester cannot keep the grant indefinitely.

---
 rtl/prio_arbiter_rr.sv | 127 ++++++++++++
 tb/tb_prio_arbiter_rr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// N-way request arbiter with registered grant outputs.
// Selection is either fixed priority (highest index wins) or round-robin.
// A grant is held until ack, requester withdrawal, or an optional hold timeout.
// Every release is followed by exactly one idle cycle before the next grant.
module prio_arbiter_rr #(
  parameter  int unsigned N        = 8,
  parameter  int unsigned RR       = 0,
  parameter  int unsigned MAX_HOLD = 0,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_onehot
);

  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]  gnt_onehot_q, gnt_onehot_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic [IW-1:0] sel_idx;
  logic          hold_expired;
  logic          release_now;

  // Pick the winning request; later loop iterations overwrite earlier ones,
  // so the last candidate visited has the highest priority.
  always_comb begin
    sel_idx = '0;
    if (RR == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) sel_idx = IW'(i);
      end
    end else begin
      // Visiting rr_ptr, rr_ptr+1, ... ends on rr_ptr-1, which therefore wins;
      // the just-granted line (rr_ptr) is visited first and is lowest priority.
      for (int unsigned j = 0; j < N; j++) begin
        int unsigned cand;
        cand = (32'(rr_ptr_q) + j) % N;
        if (req[cand]) sel_idx = IW'(cand);
      end
    end
  end

  // Release conditions while a grant is held; overlapping causes give one release.
  always_comb begin
    hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    release_now  = ack || !req[gnt_idx_q] || hold_expired;
  end

  // Next-state logic for the IDLE/GRANT controller and grant registers.
  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    hold_cnt_d   = hold_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      IDLE: begin
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
        if (|req) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = sel_idx;
          gnt_onehot_d = N'(1) << sel_idx;
          hold_cnt_d   = '0;
          rr_ptr_d     = sel_idx;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d      = IDLE;
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = '0;
          hold_cnt_d   = '0;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
        hold_cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      hold_cnt_q   <= hold_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Scoreboard bench for prio_arbiter_rr: three instances (fixed, round-robin,
// fixed with 4-cycle hold limit), each with its own inputs. The stimulus queues
// the expected grant (instance, index, length) and the monitor pops one entry
// every time an instance raises gnt_valid.
module tb_prio_arbiter_rr;

  typedef struct {
    int unsigned inst;
    int unsigned idx;
    int unsigned len;   // expected gnt_valid cycles; 0 = not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a [3];
  logic [7:0] req_a [3];
  logic       ack_a [3];
  logic       gv    [3];
  logic [2:0] gi    [3];
  logic [7:0] go    [3];
  logic       done = 1'b0;

  exp_t        exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  prio_arbiter_rr #(.N(8), .RR(0), .MAX_HOLD(0)) u_fix (
    .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]), .ack(ack_a[0]),
    .gnt_valid(gv[0]), .gnt_idx(gi[0]), .gnt_onehot(go[0])
  );

  prio_arbiter_rr #(.N(8), .RR(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]), .ack(ack_a[1]),
    .gnt_valid(gv[1]), .gnt_idx(gi[1]), .gnt_onehot(go[1])
  );

  prio_arbiter_rr #(.N(8), .RR(0), .MAX_HOLD(4)) u_hold (
    .clk(clk), .rst_n(rst_a[2]), .req(req_a[2]), .ack(ack_a[2]),
    .gnt_valid(gv[2]), .gnt_idx(gi[2]), .gnt_onehot(go[2])
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int unsigned inst, input int unsigned idx,
                              input int unsigned len);
    exp_t e;
    e.inst = inst;
    e.idx  = idx;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
    end
  endtask

  // Stimulus
  initial begin
    for (int unsigned g = 0; g < 3; g++) begin
      rst_a[g] = 1'b0;
      req_a[g] = 8'hFF;
      ack_a[g] = 1'b1;
    end
    tick(2);
    for (int unsigned g = 0; g < 3; g++) begin
      rst_a[g] = 1'b1;
      req_a[g] = 8'h00;
      ack_a[g] = 1'b0;
    end
    tick(2);

    // fixed priority: idx 5 held 5 cycles, ack, bubble, re-grant idx 5
    expect_grant(0, 5, 5);
    expect_grant(0, 5, 1);
    req_a[0] = 8'b0010_0100;
    tick(5);
    ack_a[0] = 1'b1;
    tick(1);
    ack_a[0] = 1'b0;
    tick(1);
    req_a[0] = 8'h00;
    tick(2);

    // ack coinciding with the grant load is ignored
    expect_grant(0, 3, 3);
    req_a[0] = 8'h08;
    ack_a[0] = 1'b1;
    tick(1);
    ack_a[0] = 1'b0;
    tick(2);
    req_a[0] = 8'h00;
    tick(2);

    // req[6] toggles mid-grant; granted req[3] withdraws; req[1] then wins
    expect_grant(0, 3, 3);
    expect_grant(0, 1, 1);
    req_a[0] = 8'b0000_1010;
    tick(1);
    req_a[0] = 8'b0100_1010;
    tick(1);
    req_a[0] = 8'b0000_1010;
    tick(1);
    req_a[0] = 8'b0000_0010;
    tick(2);
    req_a[0] = 8'h00;
    tick(2);

    // round-robin rotation 7..0,7,6 with ack one cycle after each grant
    for (int unsigned i = 0; i < 10; i++) expect_grant(1, (15 - i) % 8, 1);
    req_a[1] = 8'hFF;
    tick(1);
    repeat (9) begin
      ack_a[1] = 1'b1;
      tick(1);
      ack_a[1] = 1'b0;
      tick(1);
    end
    req_a[1] = 8'h00;
    tick(2);

    // reset mid-grant with rr_ptr=4; first grant after reset is idx 7
    expect_grant(1, 4, 0);
    expect_grant(1, 7, 1);
    req_a[1] = 8'h10;
    tick(2);
    rst_a[1] = 1'b0;
    tick(1);
    rst_a[1] = 1'b1;
    req_a[1] = 8'hFF;
    tick(1);
    ack_a[1] = 1'b1;
    tick(1);
    ack_a[1] = 1'b0;
    req_a[1] = 8'h00;
    tick(2);

    // hold limit 4: first grant also sees ack at the expiry edge (one release)
    for (int unsigned i = 0; i < 3; i++) expect_grant(2, 7, 4);
    req_a[2] = 8'h80;
    tick(4);
    ack_a[2] = 1'b1;
    tick(1);
    ack_a[2] = 1'b0;
    tick(10);
    req_a[2] = 8'h00;
    tick(3);

    done = 1'b1;
    tick(5);
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1);
  end

  // Monitor / scoreboard
  initial begin
    logic        vprev    [3];
    logic        rst_prev [3];
    logic        have     [3];
    int unsigned run_len  [3];
    int unsigned cur_idx  [3];
    int unsigned cur_len  [3];
    exp_t        e;
    for (int unsigned g = 0; g < 3; g++) begin
      vprev[g]    = 1'b0;
      rst_prev[g] = 1'b0;
      have[g]     = 1'b0;
      run_len[g]  = 0;
      cur_idx[g]  = 0;
      cur_len[g]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int unsigned g = 0; g < 3; g++) begin
        if (!rst_prev[g]) begin
          chk($sformatf("u%0d reset valid", g), 32'(gv[g]), 0);
          chk($sformatf("u%0d reset idx", g), 32'(gi[g]), 0);
          chk($sformatf("u%0d reset onehot", g), 32'(go[g]), 0);
        end
        if (gv[g]) begin
          if (!vprev[g]) begin
            run_len[g] = 0;
            have[g]    = 1'b0;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL u%0d unexpected grant: got idx %0d expected none at %0t",
                       g, gi[g], $time);
            end else begin
              e = exp_q.pop_front();
              if (e.inst != g) begin
                bad++;
                $display("FAIL u%0d grant order: got instance %0d expected instance %0d at %0t",
                         g, g, e.inst, $time);
              end else begin
                have[g]    = 1'b1;
                cur_idx[g] = e.idx;
                cur_len[g] = e.len;
              end
            end
          end
          run_len[g]++;
          if (have[g]) chk($sformatf("u%0d idx", g), 32'(gi[g]), cur_idx[g]);
          chk($sformatf("u%0d onehot", g), 32'(go[g]), 32'(8'd1 << gi[g]));
        end else begin
          chk($sformatf("u%0d idle onehot", g), 32'(go[g]), 0);
          if (vprev[g] && have[g] && cur_len[g] != 0)
            chk($sformatf("u%0d grant length", g), run_len[g], cur_len[g]);
          if (vprev[g]) have[g] = 1'b0;
        end
        vprev[g]    = gv[g];
        rst_prev[g] = rst_a[g];
      end
      if (done) begin
        chk("leftover expected grants", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
